// File: rtl/fft_pkg.sv
// Shared widths and complex sample/twiddle types for the FFT datapath.
package fft_pkg;

  localparam int DW_DEF   = 16;
  localparam int TW_DEF   = 16;
  localparam int PW_DEF   = DW_DEF + TW_DEF + 1;
  localparam int NFFT_DEF = 64;

  typedef struct packed {
    logic signed [DW_DEF-1:0] re;
    logic signed [DW_DEF-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [TW_DEF-1:0] re;
    logic signed [TW_DEF-1:0] im;
  } twid_t;

endpackage

// File: rtl/fft_pipe_stage.sv
// Generic valid/ready register slice. Loads when empty or when its
// current contents are taken downstream in the same cycle.
module fft_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             load;

  assign in_ready  = !valid_q || out_ready;
  assign load      = in_valid && in_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) valid_d = in_valid;
    if (load)     data_d  = in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/fft_cmul_pipe.sv
// Three-stage elastic complex multiplier (a+jb)*(c+jd) at full precision,
// with frame-length tracking and a sticky malformed-frame flag.
module fft_cmul_pipe
  import fft_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int TW    = TW_DEF,
  parameter int PW    = DW + TW + 1,
  parameter int NFFT  = NFFT_DEF,
  parameter int CNT_W = $clog2(NFFT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  input  logic [TW-1:0] tw_re,
  input  logic [TW-1:0] tw_im,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_re,
  output logic [PW-1:0] out_im,
  output logic          out_last,
  output logic          frame_err,
  output logic          busy
);

  localparam int MW  = DW + TW;
  localparam int S1W = 2 * DW + 2 * TW + 1;
  localparam int S2W = 4 * MW + 1;
  localparam int S3W = 2 * PW + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NFFT - 1);

  logic           s1_in_ready, s2_in_ready, s3_in_ready;
  logic           s1_valid, s2_valid, s3_valid;
  logic [S1W-1:0] s1_in, s1_data;
  logic [S2W-1:0] s2_in, s2_data;
  logic [S3W-1:0] s3_in, s3_data;

  logic signed [DW-1:0] a_s, b_s;
  logic signed [TW-1:0] c_s, d_s;
  logic signed [MW-1:0] p_ac, p_bd, p_ad, p_bc;
  logic signed [MW-1:0] q_ac, q_bd, q_ad, q_bc;
  logic signed [PW-1:0] sum_re, sum_im;

  assign s1_in = {in_last, in_re, in_im, tw_re, tw_im};

  fft_pipe_stage #(.WIDTH(S1W)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (s1_in_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_data)
  );

  assign a_s  = s1_data[2*DW+2*TW-1 -: DW];
  assign b_s  = s1_data[DW+2*TW-1 -: DW];
  assign c_s  = s1_data[2*TW-1 -: TW];
  assign d_s  = s1_data[TW-1:0];
  assign p_ac = MW'(a_s) * MW'(c_s);
  assign p_bd = MW'(b_s) * MW'(d_s);
  assign p_ad = MW'(a_s) * MW'(d_s);
  assign p_bc = MW'(b_s) * MW'(c_s);

  assign s2_in = {s1_data[S1W-1], p_ac, p_bd, p_ad, p_bc};

  fft_pipe_stage #(.WIDTH(S2W)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s2_in),
    .out_valid (s2_valid),
    .out_ready (s3_in_ready),
    .out_data  (s2_data)
  );

  assign q_ac = s2_data[4*MW-1 -: MW];
  assign q_bd = s2_data[3*MW-1 -: MW];
  assign q_ad = s2_data[2*MW-1 -: MW];
  assign q_bc = s2_data[MW-1:0];

  // One guard bit absorbs the (-2^(DW-1))^2 + (-2^(TW-1))^2 corner.
  assign sum_re = PW'(q_ac) - PW'(q_bd);
  assign sum_im = PW'(q_ad) + PW'(q_bc);

  assign s3_in = {s2_data[S2W-1], sum_re, sum_im};

  fft_pipe_stage #(.WIDTH(S3W)) u_s3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s2_valid),
    .in_ready  (s3_in_ready),
    .in_data   (s3_in),
    .out_valid (s3_valid),
    .out_ready (out_ready),
    .out_data  (s3_data)
  );

  assign out_valid = s3_valid;
  assign out_last  = s3_data[S3W-1];
  assign out_re    = s3_data[2*PW-1 -: PW];
  assign out_im    = s3_data[PW-1:0];
  assign busy      = s1_valid || s2_valid || s3_valid;
  assign in_ready  = rst_n && s1_in_ready;

  logic             in_acc;
  logic             at_end;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign in_acc    = in_valid && in_ready;
  assign at_end    = (cnt_q == LAST_IDX);
  assign frame_err = err_q;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (in_acc) begin
      if (in_last || at_end) cnt_d = '0;
      else                   cnt_d = cnt_q + 1'b1;
      if (in_last != at_end) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_fft_cmul_pipe.sv
// Scoreboard bench for fft_cmul_pipe: expected results queued at input
// acceptance and compared in order as the DUT emits them.
module tb_fft_cmul_pipe;
  import fft_pkg::*;

  localparam int DW = 16;
  localparam int TW = 16;
  localparam int PW = 33;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_last;
  logic [DW-1:0] in_re, in_im;
  logic [TW-1:0] tw_re, tw_im;
  logic          out_valid, out_ready, out_last;
  logic [PW-1:0] out_re, out_im;
  logic          frame_err, busy;

  fft_cmul_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .tw_re     (tw_re),
    .tw_im     (tw_im),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_last  (out_last),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    cplx_t x;
    twid_t w;
    logic  last;
  } stim_t;

  typedef struct {
    logic [PW-1:0] re;
    logic [PW-1:0] im;
    logic          last;
    int            cyc;
    bit            lat;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_out  = 0;
  bit lat_mode = 0;
  bit acc_s, rdy_s;
  bit hold_pend = 0;
  logic [PW-1:0] hold_re, hold_im;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input stim_t s);
    longint re, im;
    exp_t   e;
    re = longint'(s.x.re) * longint'(s.w.re) - longint'(s.x.im) * longint'(s.w.im);
    im = longint'(s.x.re) * longint'(s.w.im) + longint'(s.x.im) * longint'(s.w.re);
    e.re   = re[PW-1:0];
    e.im   = im[PW-1:0];
    e.last = s.last;
    e.cyc  = 0;
    e.lat  = 0;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    in_valid = 1'b1;
    in_re    = s.x.re;
    in_im    = s.x.im;
    tw_re    = s.w.re;
    tw_im    = s.w.im;
    in_last  = s.last;
  endtask

  // One clock: sample handshakes on the falling edge, then step past the rising edge.
  task automatic tick();
    stim_t s;
    exp_t  e;
    @(negedge clk);
    rdy_s = in_ready;
    acc_s = in_valid && in_ready;
    if (hold_pend && out_valid) begin
      chk("hold_re", out_re, hold_re);
      chk("hold_im", out_im, hold_im);
    end
    hold_pend = out_valid && !out_ready;
    hold_re   = out_re;
    hold_im   = out_im;
    if (acc_s) begin
      s.x.re = in_re; s.x.im = in_im; s.w.re = tw_re; s.w.im = tw_im; s.last = in_last;
      e = model(s);
      e.cyc = cyc;
      e.lat = lat_mode;
      exp_q.push_back(e);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        n_out++;
        chk("out_re", out_re, e.re);
        chk("out_im", out_im, e.im);
        chk("out_last", out_last, e.last);
        if (e.lat) chk("latency", cyc - e.cyc, 3);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Stream everything in stim_q; out_ready is low for iterations lo..hi.
  task automatic drive_all(input int lo, input int hi);
    int t = 0;
    while (stim_q.size() > 0 || exp_q.size() > 0) begin
      if (t > 2000) begin
        chk("stream_timeout", 1, 0);
        break;
      end
      if (stim_q.size() > 0) drive(stim_q[0]);
      else in_valid = 1'b0;
      out_ready = !(t >= lo && t <= hi);
      tick();
      if (acc_s) void'(stim_q.pop_front());
      if (t >= lo && t <= hi) chk("bp_in_ready", rdy_s, 0);
      if (t == hi && hi >= 0) chk("bp_buffered", exp_q.size(), 3);
      t++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  function automatic stim_t mk(input int a, input int b, input int c, input int d, input logic l);
    stim_t s;
    s.x.re = 16'(a); s.x.im = 16'(b); s.w.re = 16'(c); s.w.im = 16'(d); s.last = l;
    return s;
  endfunction

  function automatic stim_t rnd(input logic l);
    return mk(int'($urandom), int'($urandom), int'($urandom), int'($urandom), l);
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_last = 1'b0;
    in_re = '0; in_im = '0; tw_re = '0; tw_im = '0;

    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_re", out_re, 0);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    lat_mode = 1;
    stim_q.push_back(mk(3, 4, 2, -1, 1'b0));
    drive_all(-1, -1);
    tick();
    chk("basic_one_shot", out_valid, 0);

    stim_q.push_back(mk(-32768, -32768, -32768, -32768, 1'b0));
    drive_all(-1, -1);

    lat_mode = 0;
    n_out = 0;
    for (int i = 0; i < 8; i++) stim_q.push_back(rnd(1'b0));
    drive_all(4, 9);
    chk("bp_count", n_out, 8);
    chk("bp_frame_err", frame_err, 0);

    // Fill the pipe under stall, then reset with three samples in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(rnd(1'b0));
      tick();
      chk("mid_accept", acc_s, 1);
    end
    in_valid = 1'b0;
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_busy_clr", busy, 0);
    exp_q.delete();
    hold_pend = 0;
    out_ready = 1'b1;
    repeat (5) tick();

    lat_mode = 1;
    n_out = 0;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 64; i++) stim_q.push_back(rnd(i == 63));
    drive_all(-1, -1);
    chk("frames_count", n_out, 128);
    chk("frames_err", frame_err, 0);

    for (int i = 0; i < 10; i++) stim_q.push_back(rnd(i == 9));
    drive_all(-1, -1);
    chk("short_frame_err", frame_err, 1);
    for (int i = 0; i < 5; i++) stim_q.push_back(rnd(1'b0));
    drive_all(-1, -1);
    chk("err_sticky", frame_err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
